// File: rtl/phrase_writer.sv
// Text-map producer: expands string writes and screen clears
// into per-cell character RAM write strobes.
module phrase_writer #(
    parameter int          COLS      = 100,
    parameter int          ROWS      = 75,
    parameter logic [7:0]  FILL_CHAR = 8'h20,
    parameter int          ADDR_W    = 13
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_op,
    input  logic [6:0]        cmd_col,
    input  logic [6:0]        cmd_row,
    input  logic [7:0]        cmd_len,
    input  logic              char_valid,
    output logic              char_ready,
    input  logic [7:0]        char_data,
    output logic [7:0]        letters,
    output logic [ADDR_W-1:0] address,
    output logic              ready,
    output logic              busy,
    output logic              done,
    output logic              error
);

    typedef enum logic [1:0] {IDLE, WRITE, FILL, FIN} state_t;

    localparam logic [6:0]        LAST_COL = 7'(COLS - 1);
    localparam logic [6:0]        LAST_ROW = 7'(ROWS - 1);
    localparam logic [ADDR_W-1:0] COLS_A   = ADDR_W'(COLS);
    localparam logic [ADDR_W-1:0] CELLS    = ADDR_W'(COLS * ROWS);
    localparam logic [ADDR_W-1:0] ONE      = ADDR_W'(1);

    state_t            state, next;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W-1:0] remaining;
    logic [6:0]        col_cnt;
    logic [6:0]        row_cnt;
    logic              accept_cmd;
    logic              accept_char;
    logic              in_range;
    logic              last;
    logic [ADDR_W-1:0] start_ptr;

    assign accept_cmd  = cmd_valid && (state == IDLE);
    assign accept_char = char_valid && (state == WRITE);
    assign in_range    = (cmd_col <= LAST_COL) && (cmd_row <= LAST_ROW);
    assign last        = (remaining == ONE);
    assign start_ptr   = ADDR_W'(cmd_col) + COLS_A * ADDR_W'(cmd_row);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next;
    end

    // FIN waits out the final registered strobe so done never overlaps it
    always_comb begin
        next = state;
        unique case (state)
            IDLE: begin
                if (accept_cmd) begin
                    if (cmd_op)              next = FILL;
                    else if (!in_range)      next = IDLE;
                    else if (cmd_len == 8'd0) next = FIN;
                    else                     next = WRITE;
                end
            end
            WRITE: if (accept_char && last) next = FIN;
            FILL:  if (last) next = FIN;
            FIN:   if (!ready) next = IDLE;
            default: next = IDLE;
        endcase
    end

    always_comb begin
        cmd_ready  = (state == IDLE);
        char_ready = (state == WRITE);
        busy       = (state != IDLE);
        done       = (state == FIN) && !ready;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr       <= '0;
            remaining <= '0;
            col_cnt   <= '0;
            row_cnt   <= '0;
            letters   <= '0;
            address   <= '0;
            ready     <= 1'b0;
            error     <= 1'b0;
        end else begin
            ready <= 1'b0;
            error <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (accept_cmd) begin
                        if (cmd_op) begin
                            ptr       <= '0;
                            remaining <= CELLS;
                        end else if (in_range) begin
                            ptr       <= start_ptr;
                            col_cnt   <= cmd_col;
                            row_cnt   <= cmd_row;
                            remaining <= ADDR_W'(cmd_len);
                        end else begin
                            error <= 1'b1;
                        end
                    end
                end
                WRITE: begin
                    if (accept_char) begin
                        letters   <= char_data;
                        address   <= ptr;
                        ready     <= 1'b1;
                        remaining <= remaining - ONE;
                        if (col_cnt == LAST_COL) begin
                            col_cnt <= '0;
                            if (row_cnt == LAST_ROW) begin
                                row_cnt <= '0;
                                ptr     <= '0;
                            end else begin
                                row_cnt <= row_cnt + 7'd1;
                                ptr     <= ptr + ONE;
                            end
                        end else begin
                            col_cnt <= col_cnt + 7'd1;
                            ptr     <= ptr + ONE;
                        end
                    end
                end
                FILL: begin
                    letters   <= FILL_CHAR;
                    address   <= ptr;
                    ready     <= 1'b1;
                    ptr       <= ptr + ONE;
                    remaining <= remaining - ONE;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_phrase_writer.sv
// Directed bench for phrase_writer with a strobe scoreboard.
module tb_phrase_writer;

    typedef struct {
        logic [12:0] a;
        logic [7:0]  d;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_op;
    logic [6:0]  cmd_col;
    logic [6:0]  cmd_row;
    logic [7:0]  cmd_len;
    logic        char_valid;
    logic        char_ready;
    logic [7:0]  char_data;
    logic [7:0]  letters;
    logic [12:0] address;
    logic        ready;
    logic        busy;
    logic        done;
    logic        error;

    exp_t q[$];
    int   pass_cnt = 0;
    int   total_cnt = 0;
    int   strobe_cnt = 0;
    int   done_cnt = 0;
    int   err_cnt = 0;

    phrase_writer dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_col(cmd_col),
        .cmd_row(cmd_row), .cmd_len(cmd_len),
        .char_valid(char_valid), .char_ready(char_ready),
        .char_data(char_data), .letters(letters),
        .address(address), .ready(ready), .busy(busy),
        .done(done), .error(error)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (ready) begin
                strobe_cnt++;
                if (q.size() == 0) begin
                    check("unexpected_strobe", {19'd0, address}, 32'h1fff_ffff);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check("strobe_addr", {19'd0, address}, {19'd0, e.a});
                    check("strobe_data", {24'd0, letters}, {24'd0, e.d});
                end
            end
            if (done)  done_cnt++;
            if (error) err_cnt++;
        end
    end

    task automatic push(input int a, input logic [7:0] d);
        exp_t e;
        e.a = 13'(a);
        e.d = d;
        q.push_back(e);
    endtask

    task automatic send_cmd(input logic op, input logic [6:0] col,
                            input logic [6:0] row, input logic [7:0] len);
        cmd_op = op; cmd_col = col; cmd_row = row; cmd_len = len;
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic put_char(input logic [7:0] c, input int stall);
        logic acc;
        int   g;
        char_valid = 1'b0;
        if (stall > 0) begin
            repeat (stall) @(posedge clk);
            #1;
        end
        char_valid = 1'b1;
        char_data  = c;
        g = 0;
        do begin
            @(negedge clk);
            acc = char_ready;
            @(posedge clk); #1;
            g++;
        end while (!acc && g < 50);
        check("char_accepted", {31'd0, acc}, 32'd1);
    endtask

    task automatic wait_done(input int budget, output int cycles);
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (!done && cycles < budget);
        check("done_seen", {31'd0, done}, 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_ready"}, {31'd0, ready}, 32'd0);
        check({tag, "_addr"}, {19'd0, address}, 32'd0);
        check({tag, "_letters"}, {24'd0, letters}, 32'd0);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_done"}, {31'd0, done}, 32'd0);
        check({tag, "_error"}, {31'd0, error}, 32'd0);
        check({tag, "_cmd_ready"}, {31'd0, cmd_ready}, 32'd1);
        check({tag, "_char_ready"}, {31'd0, char_ready}, 32'd0);
    endtask

    initial begin
        int s0, d0, e0, cyc, g;
        reset = 1'b1; cmd_valid = 1'b0; cmd_op = 1'b0;
        cmd_col = '0; cmd_row = '0; cmd_len = '0;
        char_valid = 1'b0; char_data = '0;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        // "HI" at (2,3), back to back
        s0 = strobe_cnt; d0 = done_cnt;
        push(302, 8'h48); push(303, 8'h49);
        send_cmd(1'b0, 7'd2, 7'd3, 8'd2);
        check("hi_busy_accept", {31'd0, busy}, 32'd1);
        put_char(8'h48, 0);
        put_char(8'h49, 0);
        char_valid = 1'b0;
        @(negedge clk);
        check("hi_last_ready", {31'd0, ready}, 32'd1);
        check("hi_no_early_done", {31'd0, done}, 32'd0);
        @(negedge clk);
        check("hi_done", {31'd0, done}, 32'd1);
        check("hi_done_busy", {31'd0, busy}, 32'd1);
        check("hi_done_noready", {31'd0, ready}, 32'd0);
        @(negedge clk);
        check("hi_done_once", {31'd0, done}, 32'd0);
        check("hi_idle", {31'd0, busy}, 32'd0);
        check("hi_strobes", 32'(strobe_cnt - s0), 32'd2);
        check("hi_done_cnt", 32'(done_cnt - d0), 32'd1);
        @(posedge clk); #1;

        // wrap at bottom-right corner
        s0 = strobe_cnt; d0 = done_cnt;
        push(7499, 8'h41); push(0, 8'h42); push(1, 8'h43);
        send_cmd(1'b0, 7'd99, 7'd74, 8'd3);
        put_char(8'h41, 0); put_char(8'h42, 0); put_char(8'h43, 0);
        char_valid = 1'b0;
        wait_done(10, cyc);
        repeat (3) @(posedge clk); #1;
        check("wrap_strobes", 32'(strobe_cnt - s0), 32'd3);
        check("wrap_done_cnt", 32'(done_cnt - d0), 32'd1);

        // stalled second char
        s0 = strobe_cnt; d0 = done_cnt;
        push(302, 8'h48); push(303, 8'h49);
        send_cmd(1'b0, 7'd2, 7'd3, 8'd2);
        put_char(8'h48, 0);
        put_char(8'h49, 4);
        char_valid = 1'b0;
        wait_done(10, cyc);
        check("stall_done_lat", 32'(cyc), 32'd2);
        check("stall_strobes", 32'(strobe_cnt - s0), 32'd2);
        check("stall_done_cnt", 32'(done_cnt - d0), 32'd1);

        // full clear
        s0 = strobe_cnt; d0 = done_cnt;
        for (int i = 0; i < 7500; i++) push(i, 8'h20);
        send_cmd(1'b1, 7'd5, 7'd5, 8'd9);
        check("clr_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        check("clr_char_ready", {31'd0, char_ready}, 32'd0);
        wait_done(8000, cyc);
        check("clr_cycles", 32'(cyc), 32'd7502);
        check("clr_strobes", 32'(strobe_cnt - s0), 32'd7500);
        check("clr_done_cnt", 32'(done_cnt - d0), 32'd1);
        check("clr_queue_empty", 32'(q.size()), 32'd0);

        // zero-length write
        s0 = strobe_cnt; d0 = done_cnt;
        send_cmd(1'b0, 7'd10, 7'd10, 8'd0);
        wait_done(4, cyc);
        repeat (2) @(posedge clk); #1;
        check("len0_strobes", 32'(strobe_cnt - s0), 32'd0);
        check("len0_done_cnt", 32'(done_cnt - d0), 32'd1);

        // out-of-range column
        s0 = strobe_cnt; d0 = done_cnt; e0 = err_cnt;
        send_cmd(1'b0, 7'd100, 7'd0, 8'd2);
        @(negedge clk);
        check("err_pulse", {31'd0, error}, 32'd1);
        check("err_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        @(negedge clk);
        check("err_pulse_end", {31'd0, error}, 32'd0);
        repeat (3) @(negedge clk);
        check("err_strobes", 32'(strobe_cnt - s0), 32'd0);
        check("err_no_done", 32'(done_cnt - d0), 32'd0);
        check("err_cnt", 32'(err_cnt - e0), 32'd1);
        check("err_busy", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;

        // async reset mid-clear
        d0 = done_cnt;
        for (int i = 0; i < 7500; i++) push(i, 8'h20);
        send_cmd(1'b1, 7'd0, 7'd0, 8'd0);
        g = 0;
        do begin
            @(negedge clk);
            g++;
        end while (!(ready && address == 13'd1000) && g < 2000);
        check("rst_reach_1000", {19'd0, address}, 32'd1000);
        #1;
        reset = 1'b1;
        #1;
        check_idle_outputs("rst_async");
        q.delete();
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        check("rst_no_done", 32'(done_cnt - d0), 32'd0);

        s0 = strobe_cnt; d0 = done_cnt;
        push(302, 8'h48); push(303, 8'h49);
        send_cmd(1'b0, 7'd2, 7'd3, 8'd2);
        put_char(8'h48, 0); put_char(8'h49, 0);
        char_valid = 1'b0;
        wait_done(10, cyc);
        check("post_rst_strobes", 32'(strobe_cnt - s0), 32'd2);
        check("post_rst_done", 32'(done_cnt - d0), 32'd1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
